// File: rtl/pauli_gate_pipe_if.sv
// Stream interface for the Pauli gate pipeline: one valid/ready input port
// carrying an op and an amplitude pair, and one valid/ready result port.
interface pauli_gate_pipe_if #(
    parameter int W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic signed [W-1:0] alpha_re;
    logic signed [W-1:0] alpha_im;
    logic signed [W-1:0] beta_re;
    logic signed [W-1:0] beta_im;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_alpha_re;
    logic signed [W-1:0] out_alpha_im;
    logic signed [W-1:0] out_beta_re;
    logic signed [W-1:0] out_beta_im;
    logic                out_sat;

    // Upstream fetch / downstream write-back side
    modport master (
        output in_valid, in_op, alpha_re, alpha_im, beta_re, beta_im, out_ready,
        input  in_ready, out_valid, out_alpha_re, out_alpha_im, out_beta_re,
               out_beta_im, out_sat
    );

    // Gate unit side
    modport slave (
        input  in_valid, in_op, alpha_re, alpha_im, beta_re, beta_im, out_ready,
        output in_ready, out_valid, out_alpha_re, out_alpha_im, out_beta_re,
               out_beta_im, out_sat
    );
endinterface

// File: rtl/pauli_gate_pipe.sv
// Two-stage elastic Pauli (I/X/Y/Z) gate unit for one qubit amplitude pair.
// S1 captures the request, S2 holds the transformed result. Each stage is
// ready when empty or when its successor drains, so the pipe sustains one
// transaction per cycle and stalls cleanly under backpressure.
// W must match the W of the connected pauli_gate_pipe_if.
module pauli_gate_pipe #(
    parameter int W     = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pauli_gate_pipe_if.slave bus,
    input  logic             sat_clr,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] gate_count
);
    localparam logic [1:0] OP_I = 2'b00;
    localparam logic [1:0] OP_X = 2'b01;
    localparam logic [1:0] OP_Y = 2'b10;
    localparam logic [1:0] OP_Z = 2'b11;

    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    // Stage 1: captured request
    logic                r_s1_valid;
    logic [1:0]          r_s1_op;
    logic signed [W-1:0] r_s1_a_re, r_s1_a_im, r_s1_b_re, r_s1_b_im;

    // Stage 2: computed result presented on the output port
    logic                r_s2_valid;
    logic                r_s2_sat;
    logic signed [W-1:0] r_s2_a_re, r_s2_a_im, r_s2_b_re, r_s2_b_im;

    logic                r_sat_sticky;
    logic [CNT_W-1:0]    r_gate_count;

    logic                w_s1_ready;
    logic                w_s2_ready;
    logic                w_out_fire;
    logic                w_sat;
    logic signed [W-1:0] w_a_re, w_a_im, w_b_re, w_b_im;

    // Negation that clamps the one unrepresentable case to the most positive value
    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] x);
        return (x == MOST_NEG) ? MOST_POS : -x;
    endfunction

    assign w_s2_ready = !r_s2_valid || bus.out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_out_fire = r_s2_valid && bus.out_ready;

    // Gate transform of the S1 contents
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        w_a_re = r_s1_a_re;
        w_a_im = r_s1_a_im;
        w_b_re = r_s1_b_re;
        w_b_im = r_s1_b_im;
        w_sat  = 1'b0;
        case (r_s1_op)
            OP_I: ;
            OP_X: begin
                w_a_re = r_s1_b_re;
                w_a_im = r_s1_b_im;
                w_b_re = r_s1_a_re;
                w_b_im = r_s1_a_im;
            end
            OP_Y: begin
                // a' = -i*b, b' = i*a
                w_a_re = r_s1_b_im;
                w_a_im = sat_neg(r_s1_b_re);
                w_b_re = sat_neg(r_s1_a_im);
                w_b_im = r_s1_a_re;
                w_sat  = (r_s1_b_re == MOST_NEG) || (r_s1_a_im == MOST_NEG);
            end
            OP_Z: begin
                w_b_re = sat_neg(r_s1_b_re);
                w_b_im = sat_neg(r_s1_b_im);
                w_sat  = (r_s1_b_re == MOST_NEG) || (r_s1_b_im == MOST_NEG);
            end
            default: ;
        endcase
    end

    // Stage 1 register: accept a new request whenever the stage can move
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, so the result bus reads 0 out of reset rather than X.
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a_re  <= '0;
            r_s1_a_im  <= '0;
            r_s1_b_re  <= '0;
            r_s1_b_im  <= '0;
        end else if (w_s1_ready) begin
            // NOTE: non-blocking so each stage samples the other's previous-cycle value.
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_op   <= bus.in_op;
                r_s1_a_re <= bus.alpha_re;
                r_s1_a_im <= bus.alpha_im;
                r_s1_b_re <= bus.beta_re;
                r_s1_b_im <= bus.beta_im;
            end
        end
    end

    // Stage 2 register: load the transform, hold it while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_a_re  <= '0;
            r_s2_a_im  <= '0;
            r_s2_b_re  <= '0;
            r_s2_b_im  <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sat  <= w_sat;
                r_s2_a_re <= w_a_re;
                r_s2_a_im <= w_a_im;
                r_s2_b_re <= w_b_re;
                r_s2_b_im <= w_b_im;
            end
        end
    end

    // Completed-transaction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_count <= '0;
        end else if (w_out_fire) begin
            r_gate_count <= r_gate_count + CNT_W'(1);
        end
    end

    // Sticky saturation flag; a clear beats a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_sticky <= 1'b0;
        end else if (sat_clr) begin
            r_sat_sticky <= 1'b0;
        end else if (w_out_fire && r_s2_sat) begin
            r_sat_sticky <= 1'b1;
        end
    end

    assign bus.in_ready     = w_s1_ready;
    assign bus.out_valid    = r_s2_valid;
    assign bus.out_sat      = r_s2_sat;
    assign bus.out_alpha_re = r_s2_a_re;
    assign bus.out_alpha_im = r_s2_a_im;
    assign bus.out_beta_re  = r_s2_b_re;
    assign bus.out_beta_im  = r_s2_b_im;
    assign sat_sticky       = r_sat_sticky;
    assign gate_count       = r_gate_count;
endmodule
